// File: rtl/sccb_pkg.sv
// Shared SCCB constants and responder state encoding; the initiator side
// imports the same ID constants so both ends agree on the device address.
package sccb_pkg;

   localparam int SCCB_BYTE_BITS = 8;
   localparam int SCCB_ACK_BIT   = 8;

   localparam logic [7:0] SCCB_ID_WR = 8'h42;
   localparam logic [7:0] SCCB_ID_RD = 8'h43;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ID        = 4'd1,
      ST_ID_ACK    = 4'd2,
      ST_SUB       = 4'd3,
      ST_SUB_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_NA  = 4'd8,
      ST_IGNORE    = 4'd9
   } sccb_state_e;

   function automatic logic [7:0] sccb_read_id(input logic [7:0] wr_id);
      return wr_id | 8'h01;
   endfunction

endpackage

// File: rtl/sccb_slave_if.sv
// SCCB line and register-access port bundle; the responder takes the slave
// modport, the bench or initiator model drives through the master modport.
interface sccb_slave_if;

   logic       sioc;
   logic       siod_i;
   logic       siod_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   modport slave (
      input  sioc, siod_i, reg_rdata,
      output siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
   );

   modport master (
      output sioc, siod_i, reg_rdata,
      input  siod_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
   );

endinterface

// File: rtl/sccb_line_sync.sv
// SIOC/SIOD synchronizers and line-event detection; every event is a
// registered one-CLK pulse, SYNC_STAGES+1 CLK after the pin changes.
module sccb_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sioc,
   input  logic siod,
   output logic sioc_rise,
   output logic sioc_fall,
   output logic start,
   output logic stop,
   output logic siod_lvl
);

   logic [SYNC_STAGES-1:0] sioc_sync;
   logic [SYNC_STAGES-1:0] siod_sync;
   logic                   sioc_now;
   logic                   siod_now;
   logic                   sioc_prev;
   logic                   siod_prev;
   logic                   primed;

   // Synchronizer chains stay unreset so they already track the pins when reset drops
   always_ff @(posedge clk) begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
   end

   assign sioc_now = sioc_sync[SYNC_STAGES-1];
   assign siod_now = siod_sync[SYNC_STAGES-1];

   // Edge/condition detectors, primed from the live levels on the first cycle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         primed    <= 1'b0;
         sioc_prev <= 1'b0;
         siod_prev <= 1'b0;
         sioc_rise <= 1'b0;
         sioc_fall <= 1'b0;
         start     <= 1'b0;
         stop      <= 1'b0;
         siod_lvl  <= 1'b0;
      end else if (!primed) begin
         primed    <= 1'b1;
         sioc_prev <= sioc_now;
         siod_prev <= siod_now;
         sioc_rise <= 1'b0;
         sioc_fall <= 1'b0;
         start     <= 1'b0;
         stop      <= 1'b0;
         siod_lvl  <= siod_now;
      end else begin
         sioc_prev <= sioc_now;
         siod_prev <= siod_now;
         sioc_rise <= ~sioc_prev & sioc_now;
         sioc_fall <= sioc_prev & ~sioc_now;
         start     <= sioc_prev & sioc_now & siod_prev & ~siod_now;
         stop      <= sioc_prev & sioc_now & ~siod_prev & siod_now;
         siod_lvl  <= siod_now;
      end
   end

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase writes and 2-phase write/read transactions.
// Define SCCB_SLAVE_ACK_DRIVE_EN to pull SIOD low on the 9th bit of matched write bytes.
module sccb_slave
   import sccb_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR    = SCCB_ID_WR,
   parameter int         SYNC_STAGES = 2
) (
   input logic         CLK,
   input logic         RST,
   sccb_slave_if.slave bus
);

   localparam logic [3:0] CNT_LAST = 4'(SCCB_BYTE_BITS - 1);
   localparam logic [3:0] CNT_BYTE = 4'(SCCB_BYTE_BITS);
   localparam logic [3:0] CNT_ACK  = 4'(SCCB_ACK_BIT);
   localparam logic [3:0] CNT_DONE = 4'(SCCB_ACK_BIT + 1);
   localparam logic [7:0] RD_ADDR  = sccb_read_id(DEV_ADDR);
`ifdef SCCB_SLAVE_ACK_DRIVE_EN
   localparam logic       ACK_LVL  = 1'b1;
`else
   localparam logic       ACK_LVL  = 1'b0;
`endif

   sccb_state_e state_r, state_nx;
   logic       sioc_rise, sioc_fall, start, stop, siod_lvl;
   logic [7:0] shift_r, shift_nx, addr_r, addr_nx, wdata_r, wdata_nx, byte_in;
   logic [3:0] cnt_r, cnt_nx;
   logic       oe_r, oe_nx, we_r, we_nx, re_r, re_nx, busy_r, busy_nx, is_rd_r, is_rd_nx;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(CLK), .rst(RST), .sioc(bus.sioc), .siod(bus.siod_i),
      .sioc_rise(sioc_rise), .sioc_fall(sioc_fall),
      .start(start), .stop(stop), .siod_lvl(siod_lvl)
   );

   assign byte_in = {shift_r[6:0], siod_lvl};

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_r <= ST_IDLE;
      else     state_r <= state_nx;
   end

   // Next-state decode; line conditions override the byte sequencing
   always_comb begin
      state_nx = state_r;
      if (start) begin
         state_nx = ST_ID;
      end else if (stop) begin
         state_nx = ST_IDLE;
      end else begin
         case (state_r)
            ST_ID:        if (sioc_rise && cnt_r == CNT_LAST)
                             state_nx = (byte_in == DEV_ADDR || byte_in == RD_ADDR) ? ST_ID_ACK : ST_IGNORE;
                          else state_nx = state_r;
            ST_ID_ACK:    if (sioc_fall && cnt_r == CNT_DONE) state_nx = is_rd_r ? ST_RDATA : ST_SUB;
                          else state_nx = state_r;
            ST_SUB:       if (sioc_rise && cnt_r == CNT_LAST) state_nx = ST_SUB_ACK;
                          else state_nx = state_r;
            ST_SUB_ACK:   if (sioc_fall && cnt_r == CNT_DONE) state_nx = ST_WDATA;
                          else state_nx = state_r;
            ST_WDATA:     if (sioc_rise && cnt_r == CNT_LAST) state_nx = ST_WDATA_ACK;
                          else state_nx = state_r;
            ST_WDATA_ACK: if (sioc_fall && cnt_r == CNT_DONE) state_nx = ST_IGNORE;
                          else state_nx = state_r;
            ST_RDATA:     if (!re_r && sioc_fall && cnt_r == CNT_BYTE) state_nx = ST_RDATA_NA;
                          else state_nx = state_r;
            ST_RDATA_NA:  if (sioc_fall) state_nx = ST_IGNORE;
                          else state_nx = state_r;
            default:      state_nx = state_r;
         endcase
      end
   end

   // Output/datapath decode; cnt counts SIOC rises within the 9-bit frame
   always_comb begin
      oe_nx    = oe_r;
      addr_nx  = addr_r;
      wdata_nx = wdata_r;
      we_nx    = 1'b0;
      re_nx    = 1'b0;
      busy_nx  = busy_r;
      shift_nx = shift_r;
      cnt_nx   = cnt_r;
      is_rd_nx = is_rd_r;
      if (start) begin
         cnt_nx   = 4'd0;
         shift_nx = 8'h00;
         oe_nx    = 1'b0;
         busy_nx  = 1'b1;
         is_rd_nx = 1'b0;
      end else if (stop) begin
         cnt_nx   = 4'd0;
         shift_nx = 8'h00;
         oe_nx    = 1'b0;
         busy_nx  = 1'b0;
      end else begin
         case (state_r)
            ST_ID, ST_SUB, ST_WDATA: begin
               if (sioc_rise) begin
                  shift_nx = byte_in;
                  cnt_nx   = cnt_r + 4'd1;
                  if (cnt_r == CNT_LAST) begin
                     case (state_r)
                        ST_ID:    is_rd_nx = (byte_in == RD_ADDR);
                        ST_SUB:   addr_nx  = byte_in;
                        ST_WDATA: begin
                           wdata_nx = byte_in;
                           we_nx    = 1'b1;
                        end
                        default:  is_rd_nx = is_rd_r;
                     endcase
                  end else begin
                     is_rd_nx = is_rd_r;
                  end
               end else begin
                  shift_nx = shift_r;
               end
            end
            ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
               if (sioc_rise) begin
                  cnt_nx = cnt_r + 4'd1;
               end else if (sioc_fall && cnt_r == CNT_ACK) begin
                  oe_nx = ACK_LVL;
               end else if (sioc_fall && cnt_r == CNT_DONE) begin
                  oe_nx  = 1'b0;
                  cnt_nx = 4'd0;
                  re_nx  = (state_r == ST_ID_ACK) && is_rd_r;
               end else begin
                  cnt_nx = cnt_r;
               end
            end
            ST_RDATA: begin
               // First bit goes out on the load cycle, the rest on each SIOC fall
               if (re_r) begin
                  shift_nx = {bus.reg_rdata[6:0], 1'b0};
                  oe_nx    = ~bus.reg_rdata[7];
                  cnt_nx   = 4'd1;
               end else if (sioc_fall && cnt_r == CNT_BYTE) begin
                  oe_nx  = 1'b0;
                  cnt_nx = 4'd0;
               end else if (sioc_fall) begin
                  oe_nx    = ~shift_r[7];
                  shift_nx = {shift_r[6:0], 1'b0};
                  cnt_nx   = cnt_r + 4'd1;
               end else begin
                  cnt_nx = cnt_r;
               end
            end
            default: cnt_nx = cnt_r;
         endcase
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge CLK) begin
      if (RST) begin
         oe_r    <= 1'b0;
         addr_r  <= 8'h00;
         wdata_r <= 8'h00;
         we_r    <= 1'b0;
         re_r    <= 1'b0;
         busy_r  <= 1'b0;
         shift_r <= 8'h00;
         cnt_r   <= 4'd0;
         is_rd_r <= 1'b0;
      end else begin
         oe_r    <= oe_nx;
         addr_r  <= addr_nx;
         wdata_r <= wdata_nx;
         we_r    <= we_nx;
         re_r    <= re_nx;
         busy_r  <= busy_nx;
         shift_r <= shift_nx;
         cnt_r   <= cnt_nx;
         is_rd_r <= is_rd_nx;
      end
   end

   assign bus.siod_oe   = oe_r;
   assign bus.reg_addr  = addr_r;
   assign bus.reg_wdata = wdata_r;
   assign bus.reg_we    = we_r;
   assign bus.reg_re    = re_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-level SCCB initiator, open-drain line model and a
// register-file peripheral, checked against a stimulus-side reference memory.
module tb_sccb_slave;
   import sccb_pkg::*;

   localparam int Q = 6;
`ifdef SCCB_SLAVE_ACK_DRIVE_EN
   localparam logic ACK_EXP = 1'b0;
`else
   localparam logic ACK_EXP = 1'b1;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic siod_drv = 1'b1;
   sccb_slave_if bus();

   logic [7:0] periph  [256];
   logic [7:0] ref_mem [256];
   logic [7:0] exp_addr = 8'h00;
   logic [7:0] last_waddr = 8'h00;
   logic [7:0] last_wdata = 8'h00;
   int n_checks = 0;
   int n_fail = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int oe_cnt = 0;

   always #5 CLK = ~CLK;

   assign bus.siod_i    = siod_drv & ~bus.siod_oe;
   assign bus.reg_rdata = periph[bus.reg_addr];

   sccb_slave #(.DEV_ADDR(SCCB_ID_WR), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   // Peripheral side: commit strobed writes, count strobes and SIOD pulls
   always @(negedge CLK) begin
      if (bus.reg_we) begin
         we_cnt++;
         last_waddr = bus.reg_addr;
         last_wdata = bus.reg_wdata;
         periph[bus.reg_addr] = bus.reg_wdata;
      end
      if (bus.reg_re) re_cnt++;
      if (bus.siod_oe) oe_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic bus_start();
      siod_drv = 1'b1; tick(Q);
      bus.sioc = 1'b1; tick(Q);
      siod_drv = 1'b0; tick(Q);
      bus.sioc = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      siod_drv = 1'b0; tick(Q);
      bus.sioc = 1'b1; tick(Q);
      siod_drv = 1'b1; tick(2 * Q);
   endtask

   task automatic send_bit(input logic b);
      siod_drv = b;    tick(Q);
      bus.sioc = 1'b1; tick(2 * Q);
      bus.sioc = 1'b0; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      siod_drv = 1'b1; tick(Q);
      bus.sioc = 1'b1; tick(Q);
      ack = bus.siod_i; tick(Q);
      bus.sioc = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      siod_drv = 1'b1; tick(Q);
      bus.sioc = 1'b1; tick(Q);
      b = bus.siod_i;  tick(Q);
      bus.sioc = 1'b0; tick(Q);
   endtask

   task automatic read_byte(output logic [7:0] d, output logic na_line);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      read_bit(na_line);
   endtask

   task automatic write3(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
      logic k;
      bus_start();
      send_byte(SCCB_ID_WR, k); acks[2] = k;
      send_byte(a, k);          acks[1] = k;
      send_byte(d, k);          acks[0] = k;
   endtask

   task automatic test_reset();
      RST = 1'b1; bus.sioc = 1'b1; siod_drv = 1'b1;
      tick(6);
      n_checks++; if (bus.siod_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus.siod_oe); end
      n_checks++; if (bus.reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus.reg_addr); end
      n_checks++; if (bus.reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", bus.reg_wdata); end
      n_checks++; if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.reg_we); end
      n_checks++; if (bus.reg_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", bus.reg_re); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      RST = 1'b0;
      tick(20);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL release_no_start: busy %b want 0", bus.busy); end
   endtask

   task automatic test_write3();
      int we0 = we_cnt;
      logic [2:0] acks;
      write3(8'h12, 8'h80, acks);
      n_checks++; if (acks !== {3{ACK_EXP}}) begin n_fail++; $display("FAIL write3_acks: got %b want %b", acks, {3{ACK_EXP}}); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL write3_busy_hi: got %b want 1", bus.busy); end
      bus_stop(); tick(8);
      exp_addr = 8'h12; ref_mem[8'h12] = 8'h80;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL write3_busy_lo: got %b want 0", bus.busy); end
      n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL write3_we_count: got %0d want 1", we_cnt - we0); end
      n_checks++; if (last_waddr !== 8'h12) begin n_fail++; $display("FAIL write3_addr: got %h want 12", last_waddr); end
      n_checks++; if (last_wdata !== 8'h80) begin n_fail++; $display("FAIL write3_data: got %h want 80", last_wdata); end
   endtask

   task automatic test_read2(input logic [7:0] a, input string tag);
      int we0 = we_cnt;
      int re0;
      logic k, na;
      logic [7:0] d;
      bus_start(); send_byte(SCCB_ID_WR, k); send_byte(a, k); bus_stop(); tick(8);
      exp_addr = a;
      n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL %s_2ph_no_we: got %0d want 0", tag, we_cnt - we0); end
      n_checks++; if (bus.reg_addr !== exp_addr) begin n_fail++; $display("FAIL %s_2ph_addr: got %h want %h", tag, bus.reg_addr, exp_addr); end
      re0 = re_cnt;
      bus_start(); send_byte(SCCB_ID_RD, k);
      n_checks++; if (k !== ACK_EXP) begin n_fail++; $display("FAIL %s_rd_id_ack: got %b want %b", tag, k, ACK_EXP); end
      read_byte(d, na);
      n_checks++; if (d !== ref_mem[a]) begin n_fail++; $display("FAIL %s_rd_data: got %h want %h", tag, d, ref_mem[a]); end
      n_checks++; if (na !== 1'b1) begin n_fail++; $display("FAIL %s_rd_na_released: got %b want 1", tag, na); end
      n_checks++; if (re_cnt - re0 !== 1) begin n_fail++; $display("FAIL %s_rd_re_count: got %0d want 1", tag, re_cnt - re0); end
      bus_stop(); tick(8);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_rd_busy_lo: got %b want 0", tag, bus.busy); end
   endtask

   task automatic test_ignore();
      int we0 = we_cnt;
      int oe0 = oe_cnt;
      logic a0, a1, a2;
      bus_start(); send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h55, a2); bus_stop(); tick(8);
      n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL ignore_acks: got %b want 111", {a0, a1, a2}); end
      n_checks++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL ignore_oe: got %0d cycles want 0", oe_cnt - oe0); end
      n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL ignore_we: got %0d want 0", we_cnt - we0); end
      n_checks++; if (bus.reg_addr !== exp_addr) begin n_fail++; $display("FAIL ignore_addr: got %h want %h", bus.reg_addr, exp_addr); end
   endtask

   task automatic test_abort();
      int we0 = we_cnt;
      logic k;
      logic [2:0] acks;
      bus_start(); send_byte(SCCB_ID_WR, k); send_byte(8'h21, k);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_stop(); tick(8);
      exp_addr = 8'h21;
      n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL abort_stop_we: got %0d want 0", we_cnt - we0); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_stop_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.reg_addr !== exp_addr) begin n_fail++; $display("FAIL abort_stop_addr: got %h want %h", bus.reg_addr, exp_addr); end
      bus_start(); send_byte(SCCB_ID_WR, k);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      write3(8'h34, 8'hAA, acks);
      bus_stop(); tick(8);
      exp_addr = 8'h34; ref_mem[8'h34] = 8'hAA;
      n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL restart_we_count: got %0d want 1", we_cnt - we0); end
      n_checks++; if ({last_waddr, last_wdata} !== 16'h34AA) begin n_fail++; $display("FAIL restart_write: got %h%h want 34AA", last_waddr, last_wdata); end
   endtask

   task automatic test_reset_mid_read();
      int we0;
      logic k, b;
      logic [2:0] acks;
      periph[8'h5C] = 8'h00; ref_mem[8'h5C] = 8'h00;
      bus_start(); send_byte(SCCB_ID_WR, k); send_byte(8'h5C, k); bus_stop();
      bus_start(); send_byte(SCCB_ID_RD, k);
      for (int i = 0; i < 3; i++) read_bit(b);
      siod_drv = 1'b1; tick(Q);
      n_checks++; if (bus.siod_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_driving: got %b want 1", bus.siod_oe); end
      RST = 1'b1;
      tick(1);
      n_checks++; if (bus.siod_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b want 0", bus.siod_oe); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      tick(2);
      RST = 1'b0; bus.sioc = 1'b1; siod_drv = 1'b1;
      tick(12);
      exp_addr = 8'h00;
      we0 = we_cnt;
      write3(8'h66, 8'h99, acks); bus_stop(); tick(8);
      exp_addr = 8'h66; ref_mem[8'h66] = 8'h99;
      n_checks++; if (we_cnt - we0 !== 1 || {last_waddr, last_wdata} !== 16'h6699) begin
         n_fail++; $display("FAIL rstmid_recover: got %0d writes %h%h want 1 writes 6699", we_cnt - we0, last_waddr, last_wdata);
      end
   endtask

   task automatic test_random();
      logic [7:0] a, d, r;
      logic [7:0] written [$];
      logic [2:0] acks;
      int we0;
      for (int k = 0; k < 6; k++) begin
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom);
         we0 = we_cnt;
         write3(a, d, acks); bus_stop(); tick(8);
         ref_mem[a] = d; exp_addr = a; written.push_back(a);
         n_checks++; if (we_cnt - we0 !== 1 || {last_waddr, last_wdata} !== {a, d}) begin
            n_fail++; $display("FAIL rand_write%0d: got %0d writes %h/%h want 1 write %h/%h", k, we_cnt - we0, last_waddr, last_wdata, a, d);
         end
         r = written[$urandom_range(0, written.size() - 1)];
         test_read2(r, "rand");
      end
   endtask

   initial begin
      bus.sioc = 1'b1;
      for (int i = 0; i < 256; i++) begin
         periph[i]  = 8'($urandom);
         ref_mem[i] = periph[i];
      end
      periph[8'h0A] = 8'h76; ref_mem[8'h0A] = 8'h76;
      test_reset();
      test_write3();
      test_read2(8'h0A, "read");
      test_ignore();
      test_abort();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
